imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter LEN_W, default 11, meaning width of the word-count input.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port load_start  input  1  single-cycle request to begin a program load.
REQ-006 Port load_len  input  LEN_W  number of words to load, sampled when load_start is accepted.
REQ-007 Port rx_valid  input  1  byte-stream source has a byte.
REQ-008 Port rx_data  input  8  byte-stream data.
REQ-009 Port rx_ready  output  1  block accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-010 Port mem_we  output  1  write strobe to the instruction memory write port.
REQ-011 Port mem_waddr  output  32  word index for the write (memory indexes it directly, bits [9:0]).
REQ-012 Port mem_wdata  output  32  assembled instruction word.
REQ-013 Port busy  output  1  a load is in progress.
REQ-014 Port cpu_run  output  1  releases the core; high only after a successful load.
REQ-015 Port done  output  1  one-cycle pulse on load completion.
REQ-016 Port err  output  1  sticky error flag.

Function
REQ-017 The FSM SHALL have the states IDLE, RECV, WRITE, CHECK, DONE and ERROR.
REQ-018 In IDLE, DONE or ERROR, load_start SHALL capture load_len, clear the word and byte counters, drop cpu_run and err, and enter RECV on the next edge.
REQ-019 If the captured load_len is 0 or greater than DEPTH, the block SHALL enter ERROR instead of RECV.
REQ-020 The block SHALL ignore load_start while busy.
REQ-021 In RECV, rx_ready SHALL be 1. Bytes SHALL be assembled little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-022 The edge that accepts the fourth byte SHALL move the FSM to WRITE. In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_waddr = word counter (zero-extended) and mem_wdata = the assembled word, and rx_ready SHALL be 0.
REQ-023 After WRITE, the word counter SHALL increment. The FSM SHALL return to RECV if the counter is below load_len; otherwise it SHALL go to CHECK (macro defined) or DONE.
REQ-024 The maximum sustained rate SHALL be one word per 5 cycles. Gaps in rx_valid SHALL stall without losing bytes.
REQ-025 On entry to DONE, the block SHALL pulse done for one cycle and raise cpu_run. cpu_run SHALL hold until the next accepted load_start or reset.
REQ-026 busy SHALL be 1 in RECV, WRITE and CHECK, and 0 otherwise.
REQ-027 In ERROR, err SHALL be 1, cpu_run 0, mem_we 0, and rx_ready 0.
REQ-028 mem_we SHALL never be asserted outside WRITE. mem_waddr and mem_wdata SHALL be 0 whenever mem_we is 0.

Reset
REQ-029 Asserting rst_n low SHALL force IDLE immediately, asynchronously, at any point including mid-load.
REQ-030 During reset, all outputs SHALL be 0: rx_ready, mem_we, mem_waddr, mem_wdata, busy, cpu_run, done, err. All counters and the assembly register SHALL also clear.
REQ-031 A partially assembled word SHALL be discarded on reset. Memory contents already written SHALL be unaffected.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, the FSM SHALL enter CHECK with rx_ready=1 and accept one byte. If that byte equals the XOR of all received program bytes, the FSM SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN undefined: CHECK SHALL be unreachable, no checksum byte SHALL be consumed, and the last WRITE SHALL go directly to DONE.

Verification
REQ-034 Case: load_len=2, bytes 13 00 00 00 93 00 10 00 streamed back-to-back. Required: writes (0, 0x00000013) and (1, 0x00100093), done pulse once, cpu_run=1, busy=0.
REQ-035 Case: load_len=1 with rx_valid toggled every other cycle. Required: exactly one mem_we with the correct word, and no byte dropped or duplicated.
REQ-036 Case: load_len=0, and separately load_len=1025. Required: err=1, cpu_run=0, no mem_we.
REQ-037 Case: rst_n pulsed low after 6 bytes of a 3-word load. Required: only word 0 written, all outputs 0 during reset; a new load with load_len=1 then completes normally.
REQ-038 Case: load_start pulsed mid-load, then reissued after DONE. Required: the first pulse is ignored; the second drops cpu_run and restarts at mem_waddr=0.
REQ-039 Case (checksum enabled): a 1-word load 01 02 04 08 followed by checksum 0x0F, and the same load followed by 0x0E. Required: 0x0F gives DONE; 0x0E gives ERROR with cpu_run=0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them to IMEM, then releases the core. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             cpu_run,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [31:0]      word_q, word_d;
    logic             done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            done_q  <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        word_d    = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (load_start) begin
                    len_d  = load_len;
                    wcnt_d = '0;
                    bcnt_d = '0;
                    word_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (load_len == '0 || {1'b0, load_len} > DEPTH_L)
                        state_d = ERROR;
                    else
                        state_d = RECV;
                end
            end
            RECV: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (bcnt_q == 2'd3)
                        state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = 32'(wcnt_q);
                mem_wdata = word_q;
                wcnt_d    = wcnt_q + 1'b1;
                if (wcnt_d < len_q)
                    state_d = RECV;
                else
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_d = (rx_data == csum_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
        // done is registered so it lines up with the first cycle spent in DONE
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    assign busy    = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign cpu_run = (state_q == DONE);
    assign err     = (state_q == ERROR);
    assign done    = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-load cases plus reset / restart sequences.
// IMEM_LOADER_CHECKSUM_EN enables the trailing checksum byte and its dedicated cases.
module tb_imem_loader;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready, mem_we, busy, cpu_run, done, err;
    logic [31:0]      mem_waddr, mem_wdata;

    imem_loader #(.DEPTH(1024), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_run(cpu_run), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nerr = 0;
    int          done_cnt = 0;
    int          inv_err = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_waddr);
            wd.push_back(mem_wdata);
        end else if (mem_waddr != 32'd0 || mem_wdata != 32'd0) begin
            inv_err++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i, input bit data);
        if (wa.size() <= i) return 32'hFFFF_FFFF;
        return data ? wd[i] : wa[i];
    endfunction

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    // called at a negedge; returns at the negedge after the load_start edge
    task automatic start_load(input logic [LEN_W-1:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 50; k++) begin
            if (rx_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            ncmp++;
            nerr++;
            $display("FAIL byte_accept_timeout: byte %0h never accepted", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_prog(input logic [0:7][7:0] b, input int n, input bit gap);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], gap);
            x = x ^ b[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 30; k++) begin
            if (cpu_run) break;
            @(negedge clk);
        end
        chk({nm, "_cpu_run"}, 64'(cpu_run), 64'd1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [0:7][7:0]  b;
        bit               gap;
        bit               exp_err;
        int               exp_wr;
        logic [31:0]      w0;
        logic [31:0]      w1;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{len: 11'd2, b: {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00},
                   gap: 1'b0, exp_err: 1'b0, exp_wr: 2, w0: 32'h0000_0013, w1: 32'h0010_0093};
        tbl[1] = '{len: 11'd1, b: {8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'h0},
                   gap: 1'b1, exp_err: 1'b0, exp_wr: 1, w0: 32'hDEAD_BEEF, w1: 32'h0};
        tbl[2] = '{len: 11'd0, b: 64'h0, gap: 1'b0, exp_err: 1'b1, exp_wr: 0, w0: 32'h0, w1: 32'h0};
        tbl[3] = '{len: 11'd1025, b: 64'h0, gap: 1'b0, exp_err: 1'b1, exp_wr: 0, w0: 32'h0, w1: 32'h0};
        tbl[4] = '{len: 11'd1, b: {8'h78, 8'h56, 8'h34, 8'h12, 32'h0},
                   gap: 1'b0, exp_err: 1'b0, exp_wr: 1, w0: 32'h1234_5678, w1: 32'h0};

        rst_n = 1'b0; load_start = 1'b0; load_len = '0; rx_valid = 1'b0; rx_data = '0;
        #3;
        chk("reset_flags", 64'({rx_ready, mem_we, busy, cpu_run, done, err}), 64'd0);
        chk("reset_addr_data", 64'(mem_waddr | mem_wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            clear_log();
            start_load(tbl[t].len);
            if (tbl[t].exp_err) begin
                repeat (3) @(negedge clk);
                chk($sformatf("t%0d_err", t), 64'(err), 64'd1);
                chk($sformatf("t%0d_cpu_run", t), 64'(cpu_run), 64'd0);
                chk($sformatf("t%0d_rdy_busy", t), 64'({rx_ready, busy}), 64'd0);
            end else begin
                send_prog(tbl[t].b, tbl[t].exp_wr * 4, tbl[t].gap);
                wait_done($sformatf("t%0d", t));
                chk($sformatf("t%0d_done_cnt", t), 64'(done_cnt), 64'd1);
                chk($sformatf("t%0d_busy_err", t), 64'({busy, err}), 64'd0);
                chk($sformatf("t%0d_wa0", t), 64'(wr_at(0, 1'b0)), 64'd0);
                chk($sformatf("t%0d_wd0", t), 64'(wr_at(0, 1'b1)), 64'(tbl[t].w0));
                if (tbl[t].exp_wr > 1) begin
                    chk($sformatf("t%0d_wa1", t), 64'(wr_at(1, 1'b0)), 64'd1);
                    chk($sformatf("t%0d_wd1", t), 64'(wr_at(1, 1'b1)), 64'(tbl[t].w1));
                end
            end
            chk($sformatf("t%0d_nwr", t), 64'(wa.size()), 64'(tbl[t].exp_wr));
        end

        // reset after 6 bytes of a 3-word load
        clear_log();
        start_load(11'd3);
        send_prog({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 16'h0}, 6, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_flags", 64'({rx_ready, mem_we, busy, cpu_run, done, err}), 64'd0);
        chk("rst_mid_addr_data", 64'(mem_waddr | mem_wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_nwr", 64'(wa.size()), 64'd1);
        chk("rst_mid_wd0", 64'(wr_at(0, 1'b1)), 64'h4433_2211);
        clear_log();
        start_load(11'd1);
        send_prog({8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'h0}, 4, 1'b0);
        wait_done("rst_reload");
        chk("rst_reload_nwr", 64'(wa.size()), 64'd1);
        chk("rst_reload_wa0", 64'(wr_at(0, 1'b0)), 64'd0);
        chk("rst_reload_wd0", 64'(wr_at(0, 1'b1)), 64'hDDCC_BBAA);

        // load_start while busy is ignored; after DONE it restarts at word 0
        clear_log();
        start_load(11'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        start_load(11'd1);
        chk("mid_start_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h03 + i), 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08, 1'b0);
`endif
        wait_done("mid_start");
        chk("mid_start_nwr", 64'(wa.size()), 64'd2);
        chk("mid_start_wd1", 64'(wr_at(1, 1'b1)), 64'h0807_0605);
        clear_log();
        start_load(11'd1);
        chk("restart_run_busy", 64'({cpu_run, busy}), 64'b01);
        send_prog({8'h10, 8'h20, 8'h30, 8'h40, 32'h0}, 4, 1'b0);
        wait_done("restart");
        chk("restart_wa0", 64'(wr_at(0, 1'b0)), 64'd0);
        chk("restart_wd0", 64'(wr_at(0, 1'b1)), 64'h4030_2010);

`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_log();
        start_load(11'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(1 << i), 1'b0);
        send_byte(8'h0F, 1'b0);
        wait_done("csum_good");
        chk("csum_good_err", 64'(err), 64'd0);
        clear_log();
        start_load(11'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(1 << i), 1'b0);
        send_byte(8'h0E, 1'b0);
        repeat (2) @(negedge clk);
        chk("csum_bad_err_run", 64'({err, cpu_run}), 64'b10);
        chk("csum_bad_done", 64'(done_cnt), 64'd0);
`endif

        chk("idle_addr_data_zero", 64'(inv_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
